// File: rtl/rr_arb8_disp_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter with display.
// Holds requester count, state encoding, seven-segment glyphs and the
// rotating priority pick function.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Scan req starting at ptr, wrapping modulo N_REQ; first set bit wins.
  // Returns {found, idx}; idx is ptr when nothing is found.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [ID_W-1:0]  ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] cand;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + ID_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_arb8_disp_seg7_dec.sv
// Combinational 3-bit to active-low seven-segment decoder with blanking.
module seg7_dec
  import arb_pkg::*;
(
  input  logic [ID_W-1:0] id,
  input  logic            blank,
  output logic [6:0]      seg
);

  // Map index to glyph; blank overrides everything
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (id)
        3'd0: seg = SEG_0;
        3'd1: seg = SEG_1;
        3'd2: seg = SEG_2;
        3'd3: seg = SEG_3;
        3'd4: seg = SEG_4;
        3'd5: seg = SEG_5;
        3'd6: seg = SEG_6;
        3'd7: seg = SEG_7;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/rr_arb8_disp.sv
// Round-robin arbiter sharing one display slot among 8 requesters.
// A grant is held while its request stays high, up to HOLD_MAX cycles,
// then the pointer moves past the winner so every requester gets a turn.
// At least one idle cycle separates consecutive grants.
// Optional macro ARB_GNT_CNT_EN adds an 8-bit wrapping grant counter.
//
// Interface: req is a level request vector; a requester keeps req[i] high
// for as long as it wants the slot. gnt/gnt_id/gnt_vld/hex are registered
// and reflect the decision made at the previous rising edge.
module rr_arb8_disp
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int HOLD_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld,
  output logic [6:0]       hex
`ifdef ARB_GNT_CNT_EN
  ,
  output logic [7:0]       gnt_cnt
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, cnt_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [ID_W-1:0]   id_nxt;
  logic              vld_nxt;
  logic [6:0]        hex_nxt;
  logic              seg_blank;
  logic              new_grant;
  logic [ID_W:0]     pick;

  // Next-state and next-output decision
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = hold_cnt;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    vld_nxt   = gnt_vld;
    new_grant = 1'b0;
    pick      = rr_pick(req, ptr);
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        vld_nxt = 1'b0;
        cnt_nxt = '0;
        if (en && pick[ID_W]) begin
          state_nxt = GRANT;
          id_nxt    = pick[ID_W-1:0];
          gnt_nxt   = N_REQ'(1) << pick[ID_W-1:0];
          vld_nxt   = 1'b1;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!en) begin
          // Disable aborts the grant without moving the pointer
          state_nxt = IDLE;
          gnt_nxt   = '0;
          vld_nxt   = 1'b0;
          cnt_nxt   = '0;
        end else if (!req[gnt_id] || (hold_cnt == HOLD_LAST)) begin
          state_nxt = IDLE;
          ptr_nxt   = gnt_id + ID_W'(1);
          gnt_nxt   = '0;
          vld_nxt   = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        vld_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
    seg_blank = !vld_nxt;
  end

  seg7_dec u_seg7_dec (
    .id    (id_nxt),
    .blank (seg_blank),
    .seg   (hex_nxt)
  );

  // State, pointer, hold counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      gnt_vld  <= 1'b0;
      hex      <= SEG_BLANK;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= cnt_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= id_nxt;
      gnt_vld  <= vld_nxt;
      hex      <= hex_nxt;
    end
  end

`ifdef ARB_GNT_CNT_EN
  // Count every new grant; wraps naturally and ignores en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt <= '0;
    end else if (new_grant) begin
      gnt_cnt <= gnt_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb8_disp.sv
// Self-checking bench for rr_arb8_disp (HOLD_MAX=4). Table-driven cycle
// vectors, hand-written reset/enable sequences, a randomized phase against
// a behavioural model, and the grant counter when ARB_GNT_CNT_EN is set.
module tb_rr_arb8_disp;

  localparam int HOLD = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic [6:0] hex;
`ifdef ARB_GNT_CNT_EN
  logic [7:0] gnt_cnt;
`endif

  rr_arb8_disp #(.HOLD_MAX(HOLD), .HOLD_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .hex     (hex)
`ifdef ARB_GNT_CNT_EN
    ,
    .gnt_cnt (gnt_cnt)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference glyphs, independent of the design package
  logic [6:0] seg_ref [8];
  initial begin
    seg_ref[0] = 7'b1000000; seg_ref[1] = 7'b1111001;
    seg_ref[2] = 7'b0100100; seg_ref[3] = 7'b0110000;
    seg_ref[4] = 7'b0011001; seg_ref[5] = 7'b0010010;
    seg_ref[6] = 7'b0000010; seg_ref[7] = 7'b1111000;
  end

  int checks = 0;
  int errors = 0;

  // scoreboard: {gnt, gnt_id, gnt_vld, hex}
  logic [18:0] exp_q[$];

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [2:0] id;
    logic       vld;
  } vec_t;

  vec_t vecs [0:127];
  int   n_vec = 0;

  function automatic void add(input logic e, input logic [7:0] r,
                              input logic [2:0] id, input logic v);
    vecs[n_vec].en  = e;
    vecs[n_vec].req = r;
    vecs[n_vec].id  = id;
    vecs[n_vec].vld = v;
    n_vec++;
  endfunction

  function automatic logic [18:0] pack_exp(input logic [2:0] id, input logic v);
    logic [7:0] g;
    g = v ? (8'd1 << id) : 8'd0;
    return {g, id, v, (v ? seg_ref[id] : BLANK)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // driver: apply inputs at negedge, compare registered outputs one cycle later
  task automatic step(input string name, input logic e, input logic [7:0] r,
                      input logic [18:0] x);
    logic [18:0] want;
    en  = e;
    req = r;
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    want = exp_q.pop_front();
    check(name, {13'd0, gnt, gnt_id, gnt_vld, hex}, {13'd0, want});
  endtask

  // behavioural model for the random phase
  logic       m_busy;
  logic [2:0] m_ptr;
  logic [2:0] m_id;
  int         m_cnt;

  task automatic model_reset();
    m_busy = 1'b0; m_ptr = 3'd0; m_id = 3'd0; m_cnt = 0;
  endtask

  task automatic model(input logic e, input logic [7:0] r, output logic [18:0] x);
    logic [2:0] c;
    logic       hit;
    if (!m_busy) begin
      if (e && r != 8'd0) begin
        hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
          c = 3'((int'(m_ptr) + k) % 8);
          if (!hit && r[c]) begin hit = 1'b1; m_id = c; end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (!e) begin
      m_busy = 1'b0;
    end else if (!r[m_id] || m_cnt == HOLD - 1) begin
      m_busy = 1'b0;
      m_ptr  = 3'((int'(m_id) + 1) % 8);
    end else begin
      m_cnt++;
    end
    x = pack_exp(m_id, m_busy);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [18:0] x;
    logic        e;
    logic [7:0]  r;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'd0;

    // --- vector table ---
    add(1, 8'h10, 4, 1);            // single request, latency 1
    add(1, 8'h00, 4, 0);            // drop -> release, ptr=5
    add(1, 8'h11, 0, 1);            // from ptr 5 picks 0, not 4
    add(1, 8'h00, 0, 0);            // ptr=1
    for (int k = 1; k < 8; k++) begin   // fairness, 4-cycle holds
      for (int c = 0; c < HOLD; c++) add(1, 8'hFF, 3'(k), 1);
      add(1, 8'hFF, 3'(k), 0);
    end
    for (int c = 0; c < HOLD; c++) add(1, 8'h81, 0, 1);   // wrap: 0 then 7
    add(1, 8'h81, 0, 0);
    for (int c = 0; c < HOLD; c++) add(1, 8'h81, 7, 1);
    add(1, 8'h00, 7, 0);            // ptr=0
    add(1, 8'h08, 3, 1);            // enable drop during grant 3
    add(0, 8'h08, 3, 0);
    add(1, 8'h18, 3, 1);            // ptr not advanced: 3 wins over 4
    add(1, 8'h00, 3, 0);            // ptr=4
    add(0, 8'hFF, 3, 0);            // en=0 holds idle
    add(1, 8'h10, 4, 1);            // other requests ignored during grant
    add(1, 8'h38, 4, 1);
    add(1, 8'h00, 4, 0);            // ptr=5

    // --- reset state ---
    repeat (2) @(negedge clk);
    check("reset_gnt", {24'd0, gnt}, 32'h0);
    check("reset_id", {29'd0, gnt_id}, 32'h0);
    check("reset_vld", {31'd0, gnt_vld}, 32'h0);
    check("reset_hex", {25'd0, hex}, {25'd0, BLANK});
    rst_n = 1'b1;

    for (int i = 0; i < n_vec; i++)
      step($sformatf("vec%0d", i), vecs[i].en, vecs[i].req,
           pack_exp(vecs[i].id, vecs[i].vld));

    // --- reset mid-grant ---
    step("rst_pre_g0", 1, 8'h01, pack_exp(3'd0, 1));
    step("rst_pre_rel", 1, 8'h00, pack_exp(3'd0, 0));   // ptr=1
    step("rst_grant2", 1, 8'h04, pack_exp(3'd2, 1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_gnt", {24'd0, gnt}, 32'h0);
    check("rst_async_vld", {31'd0, gnt_vld}, 32'h0);
    check("rst_async_hex", {25'd0, hex}, {25'd0, BLANK});
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_ptr0", 1, 8'h05, {8'h01, 3'd0, 1'b1, seg_ref[0]});

    // --- randomized phase against model ---
    pulse_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: r = 8'd0;
        1: r = 8'd1 << $urandom_range(0, 7);
        2: r = 8'($urandom_range(0, 255));
        default: r = (i % 16 < 8) ? 8'hFF : r;
      endcase
      model(e, r, x);
      step($sformatf("rand%0d", i), e, r, x);
    end

`ifdef ARB_GNT_CNT_EN
    // --- grant counter wraps after 257 grants ---
    pulse_reset();
    check("cnt_reset", {24'd0, gnt_cnt}, 32'h0);
    for (int i = 0; i < 257; i++) begin
      step("cnt_g", 1, 8'h01, pack_exp(3'd0, 1));
      step("cnt_rel", 1, 8'h00, pack_exp(3'd0, 0));
    end
    step("cnt_en0", 0, 8'h01, pack_exp(3'd0, 0));
    check("cnt_wrap", {24'd0, gnt_cnt}, 32'h1);
`endif

    if (exp_q.size() != 0) check("queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
